// File: rtl/video_dnn_class_colorize.sv
// Colourises the segmentation class stream through one registered AXI4-Stream stage.
// Define VIDEO_DNN_CLASS_COLORIZE_HIST_EN to build the per-frame class histogram (hist_count, frame_done).
module video_dnn_class_colorize #(
  parameter int          TUSER_WIDTH   = 1,
  parameter int          TNUMBER_WIDTH = 4,
  parameter int          TCOUNT_WIDTH  = 1,
  parameter int          NUM_CLASS     = 11,
  parameter int          BG_CLASS      = 10,
  parameter logic [23:0] BG_COLOR      = 24'h202020,
  parameter logic [23:0] OTHER_COLOR   = 24'h00ffff,
  parameter int          HIST_WIDTH    = 20
) (
  input  logic                     aresetn,
  input  logic                     aclk,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [23:0]              m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  input  logic [TNUMBER_WIDTH-1:0] hist_sel,
  output logic [HIST_WIDTH-1:0]    hist_count,
  output logic                     frame_done
);

  localparam int NUM_BINS = NUM_CLASS + 1;
  localparam int BIN_W    = $clog2(NUM_BINS);
  localparam logic [TNUMBER_WIDTH:0]   NUM_CLASS_ID = (TNUMBER_WIDTH+1)'(NUM_CLASS);
  localparam logic [TNUMBER_WIDTH-1:0] BG_ID        = TNUMBER_WIDTH'(BG_CLASS);

  logic                   tvalid_reg;
  logic [TUSER_WIDTH-1:0] tuser_reg;
  logic                   tlast_reg;
  logic [23:0]            tdata_reg;
  logic                   s_accept;
  logic                   no_class;
  logic [23:0]            pix_color;

  assign s_axi4s_tready = !tvalid_reg || m_axi4s_tready;
  assign s_accept       = s_axi4s_tvalid && s_axi4s_tready;

  // A zero winning count means nothing was detected, whatever the class field says.
  assign no_class = (s_axi4s_tcount == '0) || ({1'b0, s_axi4s_tnumber} >= NUM_CLASS_ID);

  always_comb begin
    pix_color = OTHER_COLOR;
    if (no_class) begin
      pix_color = OTHER_COLOR;
    end else if (s_axi4s_tnumber == BG_ID) begin
      pix_color = BG_COLOR;
    end else begin
      case (s_axi4s_tnumber)
        TNUMBER_WIDTH'(0): pix_color = 24'h000000;
        TNUMBER_WIDTH'(1): pix_color = 24'h8b4513;
        TNUMBER_WIDTH'(2): pix_color = 24'hff0000;
        TNUMBER_WIDTH'(3): pix_color = 24'hff8000;
        TNUMBER_WIDTH'(4): pix_color = 24'hffff00;
        TNUMBER_WIDTH'(5): pix_color = 24'h00ff00;
        TNUMBER_WIDTH'(6): pix_color = 24'h0000ff;
        TNUMBER_WIDTH'(7): pix_color = 24'h8000ff;
        TNUMBER_WIDTH'(8): pix_color = 24'h808080;
        TNUMBER_WIDTH'(9): pix_color = 24'hffffff;
        default:           pix_color = OTHER_COLOR;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid_reg <= 1'b0;
      tuser_reg  <= '0;
      tlast_reg  <= 1'b0;
      tdata_reg  <= '0;
    end else if (s_accept) begin
      tvalid_reg <= 1'b1;
      tuser_reg  <= s_axi4s_tuser;
      tlast_reg  <= s_axi4s_tlast;
      tdata_reg  <= pix_color;
    end else if (m_axi4s_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  assign m_axi4s_tvalid = tvalid_reg;
  assign m_axi4s_tuser  = tuser_reg;
  assign m_axi4s_tlast  = tlast_reg;
  assign m_axi4s_tdata  = tdata_reg;

`ifdef VIDEO_DNN_CLASS_COLORIZE_HIST_EN
  logic [BIN_W-1:0]                     pix_bin;
  logic                                 frame_done_reg;
  logic [NUM_BINS-1:0][HIST_WIDTH-1:0] lat_cnt;
  logic [HIST_WIDTH-1:0]                hist_mux;

  // The last bin collects no-detection and out-of-range pixels.
  assign pix_bin = no_class ? BIN_W'(NUM_CLASS) : BIN_W'(s_axi4s_tnumber);

  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    logic [HIST_WIDTH-1:0] run_cnt_reg;
    logic [HIST_WIDTH-1:0] lat_cnt_reg;
    logic                  hit;

    assign hit = (pix_bin == BIN_W'(gi));

    // A frame-start pixel belongs to the new frame, so it seeds the cleared counter.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        run_cnt_reg <= '0;
        lat_cnt_reg <= '0;
      end else if (s_accept) begin
        if (s_axi4s_tuser[0]) begin
          lat_cnt_reg <= run_cnt_reg;
          run_cnt_reg <= hit ? HIST_WIDTH'(1) : '0;
        end else if (hit && (run_cnt_reg != '1)) begin
          run_cnt_reg <= run_cnt_reg + HIST_WIDTH'(1);
        end
      end
    end

    assign lat_cnt[gi] = lat_cnt_reg;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= s_accept && s_axi4s_tuser[0];
    end
  end

  always_comb begin
    hist_mux = lat_cnt[NUM_BINS-1];
    for (int i = 0; i < NUM_CLASS; i++) begin
      if ({1'b0, hist_sel} == (TNUMBER_WIDTH+1)'(i)) begin
        hist_mux = lat_cnt[i];
      end
    end
  end

  assign hist_count = hist_mux;
  assign frame_done = frame_done_reg;
`else
  logic hist_sel_unused;

  assign hist_sel_unused = ^hist_sel;
  assign hist_count      = '0;
  assign frame_done      = 1'b0;
`endif

endmodule
